// File: rtl/multi_edge_counter.sv
// multi_edge_counter: per-channel edge counter with gated window, snapshots and saturation; MULTI_EDGE_COUNTER_DEGLITCH_EN adds a 3-sample input filter
module multi_edge_counter #(
  parameter int NUM_CH = 8,
  parameter int CNT_WIDTH = 32,
  parameter int WIN_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [NUM_CH-1:0]      input_signals,
  input  logic [2*NUM_CH-1:0]    edge_mode,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear,
  input  logic [WIN_WIDTH-1:0]   window_len,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [CNT_WIDTH-1:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CH-1:0]      overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0] prev_q, prev_d, cur, ev, ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic [WIN_WIDTH-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic busy_q, busy_d, done_q, done_d, run, last, clr;

`ifdef MULTI_EDGE_COUNTER_DEGLITCH_EN
  logic [NUM_CH-1:0] h0_q, h0_d, h1_q, h1_d, stable;
  // accept a new level only once three consecutive synchronised samples agree; prev_q is the filtered level
  always_comb begin
    h0_d = sync_q[SYNC_STAGES-1];
    h1_d = h0_q;
    stable = ~(h0_d ^ h0_q) & ~(h0_q ^ h1_q);
    cur = (stable & h0_d) | (~stable & prev_q);
  end
  // filter sample history
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      h0_q <= '0;
      h1_q <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
    end
`else
  // unfiltered level straight from the synchroniser
  always_comb cur = sync_q[SYNC_STAGES-1];
`endif

  // synchroniser shift and per-channel edge detection by mode
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], input_signals};
    prev_d = cur;
    ev = '0;
    for (int c = 0; c < NUM_CH; c++)
      ev[c] = edge_mode[2*c+:2] == 2'b00 ? cur[c] & ~prev_q[c] :
              edge_mode[2*c+:2] == 2'b01 ? ~cur[c] & prev_q[c] :
              edge_mode[2*c+:2] == 2'b10 ? cur[c] ^ prev_q[c] : 1'b0;
  end

  // window FSM: last marks the final RUN cycle, whose events still count
  always_comb begin
    run = state_q == RUN;
    last = run & (abort | win_q == WIN_WIDTH'(1));
    clr = clear | (state_q == IDLE & start);
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : run ? (last ? DONE : RUN) : IDLE;
    win_d = state_q == IDLE && start ? window_len : (run && |win_q) ? win_q - WIN_WIDTH'(1) : win_q;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end

  // saturating counters; snapshots take the post-update count on the final RUN cycle
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    snap_d = snap_q;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = clr ? '0 : (run && ev[c] && !(&cnt_q[c])) ? cnt_q[c] + CNT_WIDTH'(1) : cnt_q[c];
      ovf_d[c] = clr ? 1'b0 : ovf_q[c] | (run & ev[c] & (&cnt_q[c]));
      snap_d[c] = last ? cnt_d[c] : snap_q[c];
    end
  end

  // snapshot readback mux, out-of-range selects read as zero
  always_comb rd_data_d = 32'(rd_sel) < NUM_CH ? snap_q[rd_sel] : '0;

  // all state registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      sync_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      ovf_q <= '0;
      win_q <= '0;
      rd_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      ovf_q <= ovf_d;
      win_q <= win_d;
      rd_data_q <= rd_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end

  assign rd_data = rd_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_multi_edge_counter.sv
// tb_multi_edge_counter: scoreboard bench; expected snapshots queued at start, popped by a done monitor
module tb_multi_edge_counter;
  logic clk = 0, rst_n = 0;
  logic [7:0] sig = 0;
  logic [15:0] mode = 0;
  logic start = 0, abort = 0, clear = 0;
  logic [31:0] win = 0;
  logic [2:0] rd_sel;
  logic [31:0] rd_data;
  logic busy, done;
  logic [7:0] ovf;
  logic [2:0] sig4 = 0;
  logic start4 = 0;
  logic [31:0] win4 = 0;
  logic [1:0] rd_sel4 = 0;
  logic [3:0] rd_data4;
  logic busy4, done4;
  logic [2:0] ovf4;

  typedef struct {int cyc; logic [3:0][31:0] snap; logic [7:0] ovf;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_edge_counter u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .input_signals(sig), .edge_mode(mode),
    .start(start), .abort(abort), .clear(clear), .window_len(win), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .overflow(ovf));

  multi_edge_counter #(.NUM_CH(3), .CNT_WIDTH(4)) u_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .input_signals(sig4), .edge_mode(6'b0),
    .start(start4), .abort(1'b0), .clear(1'b0), .window_len(win4), .rd_sel(rd_sel4),
    .rd_data(rd_data4), .busy(busy4), .done(done4), .overflow(ovf4));

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic exp_t mk(int c, int s0, int s1, int s2, int s3, logic [7:0] o);
    exp_t e;
    e.cyc = c;
    e.snap[0] = s0;
    e.snap[1] = s1;
    e.snap[2] = s2;
    e.snap[3] = s3;
    e.ovf = o;
    return e;
  endfunction

  task automatic go(input logic [31:0] w, output int s);
    win = w;
    start = 1;
    s = cyc;
    tick(1);
    start = 0;
  endtask

  task automatic pulses(logic [7:0] m, int n, int hi, int lo);
    repeat (n) begin
      sig = m;
      tick(hi);
      sig = 0;
      tick(lo);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      tick(1);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    tick(6);
  endtask

  initial begin
    exp_t e;
    rd_sel = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d got 1 want 0", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("overflow", {24'b0, ovf}, {24'b0, e.ovf});
          for (int ch = 0; ch < 4; ch++) begin
            rd_sel = 3'(ch);
            @(negedge clk);
            chk($sformatf("snap%0d", ch), rd_data, e.snap[ch]);
          end
          rd_sel = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int s, n;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    // ch0 rising, 10 pulses in a 100-cycle window
    go(100, s);
    q.push_back(mk(s + 101, 10, 0, 0, 0, 0));
    tick(2);
    pulses(8'h01, 10, 4, 4);
    drain();
    // rising / both / falling / disabled on the same train
    mode = {8'h00, 2'b11, 2'b01, 2'b10, 2'b00};
    go(100, s);
    q.push_back(mk(s + 101, 5, 10, 5, 0, 0));
    tick(2);
    pulses(8'h0f, 5, 4, 4);
    drain();
    // free-running window ended by abort
    mode = 0;
    go(0, s);
    tick(2);
    pulses(8'h01, 7, 4, 4);
    tick(3);
    chk("busy_free_run", busy, 1);
    abort = 1;
    q.push_back(mk(cyc + 1, 7, 0, 0, 0, 0));
    tick(1);
    abort = 0;
    drain();
    abort = 1;
    tick(1);
    abort = 0;
    tick(5);
    chk("abort_idle_busy", busy, 0);
    // clear mid-window zeroes counts, window continues
    go(60, s);
    q.push_back(mk(s + 61, 2, 0, 0, 0, 0));
    tick(2);
    pulses(8'h01, 3, 4, 4);
    clear = 1;
    tick(1);
    clear = 0;
    pulses(8'h01, 2, 4, 4);
    drain();
    // reset in the middle of RUN
    go(50, s);
    tick(2);
    pulses(8'h01, 3, 4, 4);
    rst_n = 0;
    tick(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_data", rd_data, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    chk("postrst_busy", busy, 0);
    chk("postrst_rd_data", rd_data, 0);
    go(50, s);
    q.push_back(mk(s + 51, 2, 0, 0, 0, 0));
    tick(2);
    pulses(8'h01, 2, 4, 4);
    drain();
    // short pulses: filtered out only with the deglitch build
    go(100, s);
`ifdef MULTI_EDGE_COUNTER_DEGLITCH_EN
    q.push_back(mk(s + 101, 2, 0, 0, 0, 0));
`else
    q.push_back(mk(s + 101, 4, 0, 0, 0, 0));
`endif
    tick(2);
    pulses(8'h01, 1, 1, 5);
    pulses(8'h01, 1, 2, 5);
    pulses(8'h01, 2, 3, 5);
    drain();
    // 4-bit saturation on the narrow instance
    win4 = 200;
    start4 = 1;
    s = cyc;
    tick(1);
    start4 = 0;
    tick(2);
    repeat (20) begin
      sig4 = 3'b001;
      tick(4);
      sig4 = 0;
      tick(4);
    end
    n = 0;
    while (!done4 && n < 300) begin
      tick(1);
      n++;
    end
    chk("sat_done_cycle", cyc, s + 201);
    chk("sat_ovf", ovf4, 3'b001);
    rd_sel4 = 0;
    tick(1);
    chk("sat_snap0", rd_data4, 15);
    rd_sel4 = 3;
    tick(1);
    chk("sat_rd_sel_oob", rd_data4, 0);
    win4 = 10;
    start4 = 1;
    tick(1);
    start4 = 0;
    tick(1);
    chk("sat_ovf_cleared", ovf4, 0);
    rd_sel4 = 0;
    tick(1);
    chk("sat_snap_hold", rd_data4, 15);
    tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_edge_counter.md
Name: multi_edge_counter

Overview:
Parametrised multi-channel edge counter. It replaces the fixed 8-channel rising-edge counter with per-channel edge-mode selection, a configurable width, a gated measurement window, snapshot registers and saturation flags. It sits behind the AXI-Lite register interface of the counter IP. The interface decodes registers onto the control and readback ports defined below.

Parameters:
NUM_CH, 8, number of input channels (1..32)
CNT_WIDTH, 32, width of each edge counter and snapshot
WIN_WIDTH, 32, width of the measurement-window length
SYNC_STAGES, 2, synchroniser flops per input (min 2)

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
input_signals  in  NUM_CH  asynchronous inputs to count
edge_mode  in  2*NUM_CH  per channel: 00 rising, 01 falling, 10 both, 11 disabled
start  in  1  one-cycle pulse: clear counts and begin window
abort  in  1  one-cycle pulse: end window early
clear  in  1  one-cycle pulse: zero live counters and overflow flags
window_len  in  WIN_WIDTH  window length in cycles; 0 = free-run until abort
rd_sel  in  max(1,$clog2(NUM_CH))  snapshot channel select
rd_data  out  CNT_WIDTH  selected snapshot, registered
busy  out  1  high in RUN
done  out  1  one-cycle pulse when snapshots update
overflow  out  NUM_CH  sticky per-channel saturation flags

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets all outputs to 0:
  - counters, snapshots, synchronisers, edge registers, overflow, busy, done and rd_data all 0.
  - FSM goes to IDLE.
- Input path: SYNC_STAGES flops, then one previous-sample register.
- Edge events per channel:
  - rising = cur & ~prev; falling = ~cur & prev; both = cur ^ prev; disabled = never.
  - An input change is counted SYNC_STAGES+1 cycles after it is sampled.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start -> RUN. Live counters and overflow clear, window counter loads window_len, busy=1 next cycle.
  - abort and clear in IDLE: clear zeros live counters and overflow; abort has no effect.
- RUN:
  - An event in a RUN cycle increments that channel's counter by 1.
  - Events in the start cycle itself are not counted.
  - window_len=N>0: RUN lasts exactly N cycles, then DONE.
  - window_len=0: RUN lasts until abort.
  - abort: the abort cycle's events are counted, then DONE.
  - abort in the same cycle as window expiry: a single normal DONE.
  - start in RUN is ignored.
  - clear in RUN zeros live counters and overflow; the window continues.
  - window_len is sampled only at start; later changes have no effect.
- DONE, one cycle: all live counters copy into snapshots, done=1, busy=0, then IDLE.
- Saturation:
  - A counter at all-ones holds there and sets overflow[ch].
  - overflow stays set until clear, start or reset.
- Readback: rd_data = snapshot[rd_sel], registered with 1-cycle latency.
  - rd_sel >= NUM_CH returns 0.
  - Snapshots are unchanged until the next DONE.
- Reset mid-RUN: immediate return to IDLE with everything zeroed; no done pulse.

Optional Feature:
Macro MULTI_EDGE_COUNTER_DEGLITCH_EN.
- Defined:
  - After synchronisation, a level change is accepted only after 3 consecutive equal samples.
  - Pulses shorter than 3 cycles are ignored.
  - Edge latency rises to SYNC_STAGES+3.
  - The filter's reset state is 0.
- Undefined: no filter; latency SYNC_STAGES+1.

Test Plan:
- Ch0 rising, window_len=100, 10 clean pulses (4 high / 4 low) inside the window -> done pulses at cycle start+101, snapshot0=10, overflow=0.
- Ch1 both, ch2 falling, ch3 disabled, same 5-pulse train on all -> snapshots 10, 5 and 0 respectively.
- window_len=0, 7 pulses on ch0, abort -> RUN persists until abort, then snapshot0=7 and a single done pulse; abort in IDLE afterwards -> no done.
- CNT_WIDTH=4, 20 rising edges on ch0 in a window -> snapshot0=15, overflow[0]=1; a following start clears overflow.
- Assert reset mid-RUN after 3 edges -> busy=0, done never pulses, rd_data=0; after release, start with window 50 and 2 edges -> snapshot=2.
- DEGLITCH_EN: 1- and 2-cycle pulses on ch0 -> 0 counted; 3-cycle pulses -> each counted; without the macro -> all counted.
